// File: rtl/jp5_debounce_pkg.sv
// Shared constants for the JP5 header input debouncer: register map,
// default filter length and glitch-counter saturation value.
package jp5_debounce_pkg;

  localparam logic [1:0] REG_STATE  = 2'd0;
  localparam logic [1:0] REG_LIMIT  = 2'd1;
  localparam logic [1:0] REG_BYPASS = 2'd2;
  localparam logic [1:0] REG_GLITCH = 2'd3;

  localparam int DEFAULT_LIMIT = 1000;

  localparam logic [31:0] GLITCH_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/jp5_debounce_bit.sv
// One header bit: two-flop synchronizer, stability counter, filtered level
// and a one-cycle change pulse. Flags a glitch when a pending change aborts.
module jp5_debounce_bit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_in,
  input  logic             bypass,
  input  logic [CNT_W-1:0] l_eff,
  output logic             deb,
  output logic             change_pulse,
  output logic             glitch
);

  logic             s1_q, s2_q, deb_q, pulse_q;
  logic             deb_d, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             glitch_c;

  always_comb begin
    deb_d    = deb_q;
    cnt_d    = cnt_q;
    glitch_c = 1'b0;
    if (bypass) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else if (s2_q == deb_q) begin
      // Input fell back before the count completed: abort and report it.
      if (cnt_q != '0) begin
        cnt_d    = '0;
        glitch_c = 1'b1;
      end
    end else if (cnt_q >= l_eff - CNT_W'(1)) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    pulse_d = deb_d ^ deb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      deb_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_in;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb          = deb_q;
  assign change_pulse = pulse_q;
  assign glitch       = glitch_c;

endmodule

// File: rtl/jp5_input_debouncer.sv
// JP5 header input debouncer: per-bit filters plus the Avalon-MM register
// file (limit, bypass mask, saturating glitch counter) and registered read mux.
module jp5_input_debouncer #(
  parameter int WIDTH         = 32,
  parameter int CNT_W         = 16,
  parameter int DEFAULT_LIMIT = jp5_debounce_pkg::DEFAULT_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] change_pulse
);
  import jp5_debounce_pkg::*;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == GLITCH_SAT) ? v : v + 32'd1;
  endfunction

  logic [CNT_W-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] bypass_q, bypass_d;
  logic [31:0]      gcnt_q, gcnt_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [CNT_W-1:0] l_eff;
  logic [WIDTH-1:0] deb_w, glitch_w;
  logic             wr_en;

  // A programmed limit of 0 filters exactly like a limit of 1.
  assign l_eff = (limit_q == '0) ? CNT_W'(1) : limit_q;
  assign wr_en = chipselect && !write_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jp5_debounce_bit #(.CNT_W(CNT_W)) u_bit (
      .clk          (clk),
      .reset        (reset),
      .raw_in       (raw_in[i]),
      .bypass       (bypass_q[i]),
      .l_eff        (l_eff),
      .deb          (deb_w[i]),
      .change_pulse (change_pulse[i]),
      .glitch       (glitch_w[i])
    );
  end

  always_comb begin
    limit_d  = limit_q;
    bypass_d = bypass_q;
    gcnt_d   = gcnt_q;
    if (wr_en && address == REG_LIMIT)  limit_d  = writedata[CNT_W-1:0];
    if (wr_en && address == REG_BYPASS) bypass_d = WIDTH'(writedata);
    // A clear in the same cycle as a glitch wins.
    if (wr_en && address == REG_GLITCH) gcnt_d = '0;
    else if (|glitch_w)                  gcnt_d = sat_inc(gcnt_q);

    readdata_d = '0;
    case (address)
      REG_STATE:  readdata_d = 32'(deb_w);
      REG_LIMIT:  readdata_d = 32'(limit_q);
      REG_BYPASS: readdata_d = 32'(bypass_q);
      REG_GLITCH: readdata_d = gcnt_q;
      default:    readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      limit_q    <= CNT_W'(DEFAULT_LIMIT);
      bypass_q   <= '0;
      gcnt_q     <= '0;
      readdata_q <= '0;
    end else begin
      limit_q    <= limit_d;
      bypass_q   <= bypass_d;
      gcnt_q     <= gcnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata      = readdata_q;
  assign debounced_out = deb_w;

endmodule

// File: tb/tb_jp5_input_debouncer.sv
// Directed and randomized bench for jp5_input_debouncer against a per-cycle
// behavioural model of the filter rules and register map.
module tb_jp5_input_debouncer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] raw_in;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] debounced_out;
  logic [31:0] change_pulse;

  jp5_input_debouncer dut (
    .clk           (clk),
    .reset         (reset),
    .raw_in        (raw_in),
    .chipselect    (chipselect),
    .address       (address),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .debounced_out (debounced_out),
    .change_pulse  (change_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  logic [31:0] m_s1, m_s2, m_deb, m_pulse, m_byp, m_gcnt, m_rd;
  int unsigned m_limit;
  int unsigned m_run[32];

  task automatic model_edge();
    logic [31:0] nd;
    bit          any_g;
    int unsigned leff;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_pulse = '0;
      m_byp = '0; m_gcnt = '0; m_rd = '0; m_limit = 1000;
      for (int b = 0; b < 32; b++) m_run[b] = 0;
      return;
    end
    leff  = (m_limit == 0) ? 1 : m_limit;
    nd    = m_deb;
    any_g = 1'b0;
    for (int b = 0; b < 32; b++) begin
      if (m_byp[b]) begin
        nd[b] = m_s2[b];
        m_run[b] = 0;
      end else if (m_s2[b] == m_deb[b]) begin
        if (m_run[b] != 0) any_g = 1'b1;
        m_run[b] = 0;
      end else if (m_run[b] + 1 >= leff) begin
        nd[b] = m_s2[b];
        m_run[b] = 0;
      end else begin
        m_run[b] = m_run[b] + 1;
      end
    end
    case (address)
      2'd0: m_rd = m_deb;
      2'd1: m_rd = m_limit;
      2'd2: m_rd = m_byp;
      default: m_rd = m_gcnt;
    endcase
    if (chipselect && !write_n && address == 2'd3) m_gcnt = '0;
    else if (any_g && m_gcnt != 32'hFFFF_FFFF) m_gcnt = m_gcnt + 1;
    if (chipselect && !write_n && address == 2'd1) m_limit = writedata & 32'h0000_FFFF;
    if (chipselect && !write_n && address == 2'd2) m_byp = writedata;
    m_pulse = nd ^ m_deb;
    m_deb   = nd;
    m_s2    = m_s1;
    m_s1    = raw_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("debounced_out", debounced_out, m_deb);
    chk("change_pulse", change_pulse, m_pulse);
    chk("readdata", readdata, m_rd);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    tick();
    chk(tag, readdata, exp);
  endtask

  logic [31:0] g0;

  initial begin
    reset = 1'b1; raw_in = '0; chipselect = 1'b0; address = 2'd0;
    write_n = 1'b1; writedata = '0;

    // Reset state
    ticks(2);
    chk("reset_deb", debounced_out, 32'h0);
    chk("reset_pulse", change_pulse, 32'h0);
    chk("reset_rd", readdata, 32'h0);
    reset = 1'b0;
    rd("reset_limit", 2'd1, 32'd1000);
    rd("reset_bypass", 2'd2, 32'h0);
    rd("reset_glitch", 2'd3, 32'h0);

    // Clean step, limit 4: output changes after edge 5
    wr(2'd1, 32'd4);
    address = 2'd0;
    raw_in[0] = 1'b1;
    ticks(5);
    chk("step_before", {31'b0, debounced_out[0]}, 32'd0);
    tick();
    chk("step_after", {31'b0, debounced_out[0]}, 32'd1);
    chk("step_pulse", change_pulse, 32'h1);
    tick();
    chk("step_pulse_end", change_pulse, 32'h0);
    rd("step_glitch", 2'd3, 32'd0);

    // Glitch reject: bit 3 high for 3 cycles
    raw_in[3] = 1'b1;
    ticks(3);
    raw_in[3] = 1'b0;
    ticks(8);
    chk("glitch_deb3", {31'b0, debounced_out[3]}, 32'd0);
    rd("glitch_cnt", 2'd3, 32'd1);

    // Bypass on bit 0; bit 1 toggles alongside and stays filtered
    wr(2'd1, 32'd1000);
    wr(2'd2, 32'h1);
    address = 2'd0;
    raw_in[1:0] = 2'b00;
    ticks(2);
    chk("byp_hold", {31'b0, debounced_out[0]}, 32'd1);
    tick();
    chk("byp_follow0", {31'b0, debounced_out[0]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      raw_in[1:0] = ~raw_in[1:0];
      ticks(3);
      chk("byp_follow", {31'b0, debounced_out[0]}, {31'b0, raw_in[0]});
      chk("byp_filtered1", {31'b0, debounced_out[1]}, 32'd0);
    end

    // Limit 0 behaves as limit 1
    wr(2'd2, 32'h0);
    wr(2'd1, 32'd0);
    rd("limit0_read", 2'd1, 32'd0);
    raw_in = '0;
    ticks(4);
    raw_in[2] = 1'b1;
    ticks(2);
    chk("limit0_before", {31'b0, debounced_out[2]}, 32'd0);
    tick();
    chk("limit0_after", {31'b0, debounced_out[2]}, 32'd1);

    // Simultaneous glitches on bits 0 and 5 count once
    wr(2'd1, 32'd4);
    raw_in = '0;
    ticks(12);
    address = 2'd3;
    tick();
    g0 = readdata;
    raw_in[0] = 1'b1; raw_in[5] = 1'b1;
    ticks(2);
    raw_in = '0;
    ticks(8);
    rd("dual_glitch", 2'd3, g0 + 32'd1);

    // Clear written in the very cycle a glitch is flagged
    raw_in[5] = 1'b1;
    ticks(2);
    raw_in[5] = 1'b0;
    ticks(2);
    wr(2'd3, 32'h0);
    rd("clear_wins", 2'd3, 32'd0);

    // Reset mid-count with limit 8
    wr(2'd1, 32'd8);
    address = 2'd0;
    raw_in[4] = 1'b1;
    ticks(5);
    reset = 1'b1;
    tick();
    chk("rst_mid_deb", debounced_out, 32'h0);
    chk("rst_mid_pulse", change_pulse, 32'h0);
    chk("rst_mid_rd", readdata, 32'h0);
    reset = 1'b0;
    wr(2'd1, 32'd8);
    address = 2'd0;
    ticks(8);
    chk("rst_rel_before", {31'b0, debounced_out[4]}, 32'd0);
    tick();
    chk("rst_rel_after", {31'b0, debounced_out[4]}, 32'd1);

    // Randomized traffic against the model
    wr(2'd1, 32'd3);
    wr(2'd2, $urandom & $urandom);
    for (int n = 0; n < 600; n++) begin
      raw_in     = raw_in ^ ($urandom & $urandom & $urandom);
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 9) == 0);
      write_n    = ($urandom_range(0, 1) == 1);
      writedata  = (address == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    ticks(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
